// File: rtl/uart_rx_packer.sv
// Collects UART Rx FIFO bytes into tagged, sequenced 51-bit packets with a ready/valid handshake.
// Optional partial-packet flush timer enabled by defining RX_PACKER_TIMEOUT_EN.
`timescale 1ns/1ps
module uart_rx_packer #(
  parameter int unsigned DATA_PACKET_WIDTH = 51,
  parameter int unsigned UART_FIFO_WIDTH   = 8,
  parameter int unsigned STROBE_WIDTH      = 4,
  parameter logic [6:0]  PERIPH_ID         = 7'h01,
  parameter int unsigned TIMEOUT_CYCLES    = 1000
) (
  input  logic                         clk1,
  input  logic                         rst_n,
  input  logic                         rd_f_empty,
  input  logic [UART_FIFO_WIDTH-1:0]   rd_fifo_data,
  output logic                         rd_fifo_en,
  output logic                         pkt_valid,
  input  logic                         pkt_ready,
  output logic [DATA_PACKET_WIDTH-1:0] pkt_data
);

  localparam int unsigned DataW = UART_FIFO_WIDTH * STROBE_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_e;

  state_e                  state;
  logic [DataW-1:0]        data, data_nxt;
  logic [STROBE_WIDTH-1:0] strobe, strobe_nxt;
  logic [2:0]              byte_cnt;
  logic [7:0]              seq;
  logic                    last_byte;

`ifdef RX_PACKER_TIMEOUT_EN
  logic [15:0]             timer;
`else
  logic                    unused_timeout;
  assign unused_timeout = ^16'(TIMEOUT_CYCLES);
`endif

  // Gated by rst_n so no read strobe is seen while reset is held.
  assign rd_fifo_en = rst_n && (state == S_IDLE) && !rd_f_empty;
  assign last_byte  = (byte_cnt + 3'd1) == 3'(STROBE_WIDTH);

  // Lane write of the byte returned by the previous read.
  always_comb begin
    data_nxt   = data;
    strobe_nxt = strobe;
    for (int k = 0; k < STROBE_WIDTH; k++) begin
      if (byte_cnt == 3'(k)) begin
        data_nxt[k*UART_FIFO_WIDTH +: UART_FIFO_WIDTH] = rd_fifo_data;
        strobe_nxt[k]                                  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      data      <= '0;
      strobe    <= '0;
      byte_cnt  <= '0;
      seq       <= '0;
      pkt_valid <= 1'b0;
      pkt_data  <= '0;
`ifdef RX_PACKER_TIMEOUT_EN
      timer     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (!rd_f_empty) begin
            state <= S_WAIT;
`ifdef RX_PACKER_TIMEOUT_EN
            timer <= '0;
          end else if (byte_cnt != 3'd0) begin
            if (timer == 16'(TIMEOUT_CYCLES - 1)) begin
              pkt_data  <= {PERIPH_ID, seq, strobe, data};
              pkt_valid <= 1'b1;
              state     <= S_SEND;
            end else begin
              timer <= timer + 16'd1;
            end
`endif
          end
        end
        S_WAIT: begin
          data     <= data_nxt;
          strobe   <= strobe_nxt;
          byte_cnt <= byte_cnt + 3'd1;
`ifdef RX_PACKER_TIMEOUT_EN
          timer    <= '0;
`endif
          if (last_byte) begin
            pkt_data  <= {PERIPH_ID, seq, strobe_nxt, data_nxt};
            pkt_valid <= 1'b1;
            state     <= S_SEND;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SEND: begin
          if (pkt_ready) begin
            pkt_valid <= 1'b0;
            pkt_data  <= '0;
            seq       <= seq + 8'd1;
            data      <= '0;
            strobe    <= '0;
            byte_cnt  <= '0;
`ifdef RX_PACKER_TIMEOUT_EN
            timer     <= '0;
`endif
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_packer.sv
// Directed bench for uart_rx_packer: vector table for full packets plus hand-written
// sequences for stall, partial flush/no-flush, reset mid-packet and sequence wrap.
`timescale 1ns/1ps
module tb_uart_rx_packer;

  localparam int unsigned To = 24;

  logic        clk1 = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_f_empty;
  logic [7:0]  rd_fifo_data;
  logic        rd_fifo_en;
  logic        pkt_valid;
  logic        pkt_ready = 1'b0;
  logic [50:0] pkt_data;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  exp_seq = 8'd0;

  // Rx FIFO model: data appears the cycle after the read strobe.
  logic [7:0]  mem [0:1023];
  int          wr_ptr = 0;
  int          rd_ptr = 0;

  assign rd_f_empty = (wr_ptr == rd_ptr);

  always @(posedge clk1) begin
    if (rd_fifo_en) begin
      rd_fifo_data <= mem[rd_ptr % 1024];
      rd_ptr       <= rd_ptr + 1;
    end
  end

  always #5 clk1 = ~clk1;

  uart_rx_packer #(
    .TIMEOUT_CYCLES(To)
  ) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .rd_f_empty  (rd_f_empty),
    .rd_fifo_data(rd_fifo_data),
    .rd_fifo_en  (rd_fifo_en),
    .pkt_valid   (pkt_valid),
    .pkt_ready   (pkt_ready),
    .pkt_data    (pkt_data)
  );

  typedef struct packed {
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] exp_data;
    logic [15:0] stall;
    logic        lat;
    logic        ahead;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr % 1024] = b;
    wr_ptr++;
  endtask

  task automatic push4(input vec_t v);
    push(v.b0);
    push(v.b1);
    push(v.b2);
    push(v.b3);
    #1;
  endtask

  task automatic get_pkt(input int stall, input logic [31:0] d, input logic [3:0] s);
    logic [50:0] exp;
    int          w;
    exp = {7'h01, exp_seq, s, d};
    w   = 0;
    while (!pkt_valid && w < 60) begin
      @(negedge clk1);
      w++;
    end
    if (!pkt_valid) begin
      n_cmp++;
      n_err++;
      $display("FAIL pkt_wait: pkt_valid still 0 after %0d cycles, expected 1", w);
      return;
    end
    check("pkt_data", pkt_data, exp);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk1);
      check("stall_data", pkt_data, exp);
      check("stall_valid", pkt_valid, 1);
      check("stall_rd_en", rd_fifo_en, 0);
    end
    pkt_ready = 1'b1;
    @(negedge clk1);
    pkt_ready = 1'b0;
    exp_seq++;
    check("valid_drop", pkt_valid, 0);
  endtask

  vec_t vecs [4];

  initial begin
    int pushed;
    int w;
    vecs[0] = '{8'h11, 8'h22, 8'h33, 8'h44, 32'h44332211, 16'd0,  1'b1, 1'b0};
    vecs[1] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 32'hEFBEADDE, 16'd20, 1'b0, 1'b1};
    vecs[2] = '{8'h01, 8'h02, 8'h03, 8'h04, 32'h04030201, 16'd0,  1'b0, 1'b0};
    vecs[3] = '{8'h00, 8'hFF, 8'h80, 8'h7F, 32'h7F80FF00, 16'd3,  1'b0, 1'b0};

    // Reset state
    #2;
    check("rst_valid", pkt_valid, 0);
    check("rst_data", pkt_data, 0);
    check("rst_rd_en", rd_fifo_en, 0);
    @(negedge clk1);
    @(negedge clk1);
    rst_n = 1'b1;

    // pkt_ready with nothing valid must not bump seq
    pkt_ready = 1'b1;
    repeat (5) @(negedge clk1);
    pkt_ready = 1'b0;
    check("idle_valid", pkt_valid, 0);

    // Table-driven full packets
    pushed = 0;
    for (int i = 0; i < 4; i++) begin
      if (pushed <= i) begin
        push4(vecs[i]);
        pushed = i + 1;
      end
      if (vecs[i].ahead && pushed <= i + 1 && i < 3) begin
        push4(vecs[i+1]);
        pushed = i + 2;
      end
      if (vecs[i].lat) begin
        check("first_rd_en", rd_fifo_en, 1);
        repeat (7) @(negedge clk1);
        check("lat_7", pkt_valid, 0);
        @(negedge clk1);
        check("lat_8", pkt_valid, 1);
      end
      get_pkt(int'(vecs[i].stall), vecs[i].exp_data, 4'hF);
    end

    // Single byte then empty FIFO
    push(8'hA5);
    #1;
    check("part_rd_en", rd_fifo_en, 1);
`ifdef RX_PACKER_TIMEOUT_EN
    repeat (To + 1) @(negedge clk1);
    check("flush_early", pkt_valid, 0);
    @(negedge clk1);
    check("flush_due", pkt_valid, 1);
    get_pkt(0, 32'h000000A5, 4'h1);

    // Byte lands in the expiry cycle: read wins, no flush
    push(8'h5A);
    #1;
    repeat (To + 1) @(negedge clk1);
    push(8'h6B);
    #1;
    check("exp_rd_en", rd_fifo_en, 1);
    check("exp_valid", pkt_valid, 0);
    @(negedge clk1);
    check("no_flush", pkt_valid, 0);
    push(8'h7C);
    push(8'h8D);
    get_pkt(0, 32'h8D7C6B5A, 4'hF);
`else
    repeat (To + 10) @(negedge clk1);
    check("no_partial", pkt_valid, 0);
    push(8'hA1);
    push(8'hB2);
    push(8'hC3);
    get_pkt(0, 32'hC3B2A1A5, 4'hF);
`endif

    // Reset after two bytes captured
    push(8'h01);
    push(8'h02);
    #1;
    repeat (4) @(negedge clk1);
    rst_n = 1'b0;
    push(8'h10);
    push(8'h20);
    push(8'h30);
    push(8'h40);
    #1;
    check("mid_rst_rd_en", rd_fifo_en, 0);
    check("mid_rst_valid", pkt_valid, 0);
    check("mid_rst_data", pkt_data, 0);
    repeat (3) @(negedge clk1);
    check("mid_rst_rd_en2", rd_fifo_en, 0);
    rst_n = 1'b1;
    exp_seq = 8'd0;
    get_pkt(0, 32'h40302010, 4'hF);

    // 257 packets from a fresh reset: seq wraps on the last one
    rst_n = 1'b0;
    @(negedge clk1);
    rst_n = 1'b1;
    exp_seq = 8'd0;
    for (int i = 0; i < 257; i++) begin
      push(8'(i));
      push(8'(i + 1));
      push(8'(i + 2));
      push(8'(i + 3));
      if (i == 256) begin
        w = 0;
        while (!pkt_valid && w < 60) begin
          @(negedge clk1);
          w++;
        end
        check("wrap_seq", pkt_data[43:36], 8'h00);
      end
      get_pkt(0, {8'(i + 3), 8'(i + 2), 8'(i + 1), 8'(i)}, 4'hF);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
